rf_scoreboard: RTL
==================

// Module: rf_scoreboard
// PURPOSE
//  Issue-side hazard tracker sitting directly upstream of the RF read ports.
//  Counts outstanding writes per architectural register; blocks issue of an
//  instruction whose sources (RAW) or destination (counter saturation) are busy.
//  Writeback port mirrors the RF write port (we/dst_addr), retiring pending writes.
//  R0 is hardwired zero in the RF; never tracked, never blocks.
// PARAMETERS
//  NREG   16  architectural registers (address width = $clog2(NREG) = 4)
//  CNT_W  2   per-register pending-write counter width (max 2**CNT_W-1 in flight)
//  TOT_W  5   total in-flight counter width
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      sync: discard all in-flight tracking (pipeline kill)
//  iss_valid    in   1      decode presents an instruction
//  iss_ready    out  1      scoreboard accepts it this cycle (comb.)
//  iss_src0     in   4      source 0 address (RF p0_addr)
//  iss_src0_use in   1      source 0 actually read
//  iss_src1     in   4      source 1 address (RF p1_addr)
//  iss_src1_use in   1      source 1 actually read
//  iss_dst      in   4      destination address
//  iss_dst_we   in   1      instruction writes iss_dst
//  wb_we        in   1      writeback this cycle (same signal as RF we)
//  wb_addr      in   4      writeback register (RF dst_addr)
//  busy_vec     out  NREG   bit r = counter[r]!=0 (registered state)
//  inflight     out  TOT_W  total outstanding writes
//  idle         out  1      inflight==0
//  err          out  1      sticky: wb to a register whose counter was 0
// BEHAVIOUR
//  - Reset: all counters 0, busy_vec=0, inflight=0, idle=1, err=0.
//  - Fire = iss_valid & iss_ready. Issue is one-cycle; no internal queueing.
//  - src hazard(s) = use & addr!=0 & cnt[addr]!=0 (bypass relaxation below).
//  - dst hazard = iss_dst_we & iss_dst!=0 & cnt[iss_dst]==max & ~(wb clears it).
//  - iss_ready = ~flush & ~hazard(src0) & ~hazard(src1) & ~dst hazard
//    & ~(inflight==2**TOT_W-1 & dst counted). iss_ready valid with iss_valid=0.
//  - Per cycle, per reg r!=0: inc = fire&iss_dst_we&iss_dst==r;
//    dec = wb_we&wb_addr==r&cnt[r]!=0. inc&dec -> unchanged; inc -> +1; dec -> -1.
//  - inflight tracks sum of inc/dec identically; never wraps.
//  - wb_we with wb_addr==0: ignored (no dec, no err).
//  - wb_we to reg with cnt==0: no change, err<=1 until reset.
//  - flush: next edge all counters/inflight <= 0; err kept; a wb in the same
//    cycle is dropped (no err); iss_ready=0 that cycle.
//  - rst_n low mid-operation: immediate clear, regardless of clk.
//  - dst==src self-dependence is judged on pre-issue count only.
// CONFIGURATION
//  SB_WB_BYPASS_EN defined: RF writes on clk high, reads on clk low, so a
//   source whose cnt==1 and matches wb_we/wb_addr this cycle is not a hazard
//   (issue same cycle as writeback). Same relaxation for dst saturation.
//  Not defined: any cnt!=0 blocks; issue earliest the cycle after writeback.
//   +1 cycle load-use penalty; simpler timing.
// TESTING
//  1. Reset, issue dst=R3; next cycle src0=R3 -> iss_ready=0, busy_vec[3]=1,
//     inflight=1; wb R3 -> cnt 0, src0=R3 issues (same cycle if bypass built).
//  2. Three issues to dst=R5 (CNT_W=2) -> cnt=3; fourth dst=R5 iss_ready=0
//     until wb R5; issue+wb R5 same cycle -> cnt stays 3.
//  3. dst/src = R0 with wb_we addr 0 -> never blocks, busy_vec=0, err=0.
//  4. wb R7 with cnt[7]=0 -> err=1, counters unchanged; stays 1 after flush.
//  5. Outstanding R1,R2,R9 then flush with wb R1 same cycle -> next cycle
//     busy_vec=0, inflight=0, idle=1, err=0; iss_ready=0 during flush cycle.
//  6. rst_n asserted between edges with inflight=4 -> outputs zero at once,
//     idle=1 before next clk edge.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracker that gates instruction issue on RAW and
// counter-saturation hazards. Optional macro SB_WB_BYPASS_EN allows issue alongside the retiring writeback.
module rf_scoreboard #(
  parameter  int NREG  = 16,
  parameter  int CNT_W = 2,
  parameter  int TOT_W = 5,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [AW-1:0]    iss_src0,
  input  logic             iss_src0_use,
  input  logic [AW-1:0]    iss_src1,
  input  logic             iss_src1_use,
  input  logic [AW-1:0]    iss_dst,
  input  logic             iss_dst_we,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  output logic [NREG-1:0]  busy_vec,
  output logic [TOT_W-1:0] inflight,
  output logic             idle,
  output logic             err
);

`ifdef SB_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [TOT_W-1:0] inflight_q;
  logic             err_q;

  logic wb_live, wb_dec, wb_err;
  logic dst_counted, src0_hz, src1_hz, dst_hz, tot_hz, inc;

  // Counters never wrap: increments are pre-gated by iss_ready, decrements by a non-zero count.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc_i, input logic dec_i);
    if (inc_i && !dec_i && c != CNT_MAX) return c + CNT_W'(1);
    if (dec_i && !inc_i && c != '0)      return c - CNT_W'(1);
    return c;
  endfunction

  function automatic logic [TOT_W-1:0] tot_step(input logic [TOT_W-1:0] t,
                                                input logic inc_i, input logic dec_i);
    if (inc_i && !dec_i && t != TOT_MAX) return t + TOT_W'(1);
    if (dec_i && !inc_i && t != '0)      return t - TOT_W'(1);
    return t;
  endfunction

  // A source pending exactly once is satisfied by a same-cycle writeback only in bypass builds.
  function automatic logic src_hazard(input logic use_i, input logic [AW-1:0] addr,
                                      input logic [CNT_W-1:0] c, input logic wb_hit);
    return use_i && (addr != '0) && (c != '0) && !(BYPASS && wb_hit && (c == CNT_ONE));
  endfunction

  assign wb_live     = wb_we && (wb_addr != '0) && !flush;
  assign wb_dec      = wb_live && (cnt_q[wb_addr] != '0);
  assign wb_err      = wb_live && (cnt_q[wb_addr] == '0);
  assign dst_counted = iss_dst_we && (iss_dst != '0);

  assign src0_hz = src_hazard(iss_src0_use, iss_src0, cnt_q[iss_src0],
                              wb_dec && (wb_addr == iss_src0));
  assign src1_hz = src_hazard(iss_src1_use, iss_src1, cnt_q[iss_src1],
                              wb_dec && (wb_addr == iss_src1));
  assign dst_hz  = dst_counted && (cnt_q[iss_dst] == CNT_MAX)
                   && !(BYPASS && wb_dec && (wb_addr == iss_dst));
  assign tot_hz  = dst_counted && (inflight_q == TOT_MAX);

  assign iss_ready = !flush && !src0_hz && !src1_hz && !dst_hz && !tot_hz;
  assign inc       = iss_valid && iss_ready && dst_counted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wb_err) err_q <= 1'b1;
      if (flush) begin
        for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        inflight_q <= '0;
      end else begin
        cnt_q[0] <= '0;
        for (int r = 1; r < NREG; r++)
          cnt_q[r] <= cnt_step(cnt_q[r], inc && (iss_dst == AW'(r)),
                               wb_dec && (wb_addr == AW'(r)));
        inflight_q <= tot_step(inflight_q, inc, wb_dec);
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt_q[r] != '0);
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0);
  assign err      = err_q;

endmodule
